// File: rtl/kb_query_arbiter.sv
// kb_query_arbiter
//
// Shares the single lookup port of the keyboard key-state memory between two clients:
//   - a CPU/MMIO point query (cpu_req/cpu_addr -> cpu_ack/cpu_pressed)
//   - an internal scan engine that walks [scan_lo, scan_hi] and reports the first pressed
//     code (scan_start -> scan_busy/scan_done/scan_hit/scan_code)
// Only this block drives the memory address.
//
// Ports:
//   clk, rst         clock; synchronous active-low reset
//   kb_addr          registered lookup address to the key-state memory
//   kb_is_pressed    key-state memory read data, sampled READ_LAT edges after kb_addr loads
//   cpu_req/addr     CPU query request (level, held until ack) and ASCII code
//   cpu_ack          one-cycle pulse, cpu_pressed valid
//   cpu_pressed      query result, held until the next ack
//   scan_start       one-cycle pulse, accepted only while idle (scan_busy == 0)
//   scan_lo/hi       inclusive scan range, sampled at an accepted start
//   scan_busy        scan in progress
//   scan_done        one-cycle pulse at the end of a scan
//   scan_hit/code    first pressed code found (code is 0 when there was no hit)
module kb_query_arbiter #(
  parameter int unsigned READ_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] kb_addr,
  input  logic       kb_is_pressed,
  input  logic       cpu_req,
  input  logic [7:0] cpu_addr,
  output logic       cpu_ack,
  output logic       cpu_pressed,
  input  logic       scan_start,
  input  logic [7:0] scan_lo,
  input  logic [7:0] scan_hi,
  output logic       scan_busy,
  output logic       scan_done,
  output logic       scan_hit,
  output logic [7:0] scan_code
);

  localparam int unsigned CntW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef enum logic {StIdle, StLookup} state_e;
  typedef enum logic {OwnCpu, OwnScan} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            rr_last_q, rr_last_d;
  owner_e            grant;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [7:0]        kb_addr_q, kb_addr_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              cpu_pressed_q, cpu_pressed_d;
  logic              scan_busy_q, scan_busy_d;
  logic              scan_done_q, scan_done_d;
  logic              scan_hit_q, scan_hit_d;
  logic [7:0]        scan_code_q, scan_code_d;
  logic [7:0]        scan_ptr_q, scan_ptr_d;
  logic [7:0]        scan_end_q, scan_end_d;
  logic              cpu_pend;
  logic              scan_pend;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rr_last_d     = rr_last_q;
    cnt_d         = cnt_q;
    kb_addr_d     = kb_addr_q;
    cpu_ack_d     = 1'b0;
    cpu_pressed_d = cpu_pressed_q;
    scan_busy_d   = scan_busy_q;
    scan_done_d   = 1'b0;
    scan_hit_d    = scan_hit_q;
    scan_code_d   = scan_code_q;
    scan_ptr_d    = scan_ptr_q;
    scan_end_d    = scan_end_q;
    grant         = OwnCpu;
    // Masking with the ack pulse stops a still-high cpu_req from being granted twice.
    cpu_pend      = cpu_req & ~cpu_ack_q;
    scan_pend     = scan_busy_q;

    unique case (state_q)
      StIdle: begin
        if (cpu_pend || scan_pend) begin
          if (cpu_pend && scan_pend) begin
            grant = (rr_last_q == OwnCpu) ? OwnScan : OwnCpu;
          end else begin
            grant = cpu_pend ? OwnCpu : OwnScan;
          end
          kb_addr_d = (grant == OwnCpu) ? cpu_addr : scan_ptr_q;
          owner_d   = grant;
          rr_last_d = grant;
          cnt_d     = CntW'(READ_LAT - 1);
          state_d   = StLookup;
        end
      end
      StLookup: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
          if (owner_q == OwnCpu) begin
            cpu_pressed_d = kb_is_pressed;
            cpu_ack_d     = 1'b1;
          end else if (kb_is_pressed) begin
            scan_code_d = scan_ptr_q;
            scan_hit_d  = 1'b1;
            scan_busy_d = 1'b0;
            scan_done_d = 1'b1;
          end else if (scan_ptr_q == scan_end_q) begin
            // Equality test before increment: a range ending at 8'hFF never wraps.
            scan_busy_d = 1'b0;
            scan_done_d = 1'b1;
          end else begin
            scan_ptr_d = scan_ptr_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
    endcase

    // A scan owner can only be mid-lookup while busy, so this never collides with the
    // completion logic above.
    if (scan_start && !scan_busy_q) begin
      scan_ptr_d  = scan_lo;
      scan_end_d  = scan_hi;
      scan_hit_d  = 1'b0;
      scan_code_d = 8'h00;
      if (scan_lo > scan_hi) begin
        scan_done_d = 1'b1;
      end else begin
        scan_busy_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StIdle;
      owner_q       <= OwnCpu;
      rr_last_q     <= OwnScan;
      cnt_q         <= '0;
      kb_addr_q     <= 8'h00;
      cpu_ack_q     <= 1'b0;
      cpu_pressed_q <= 1'b0;
      scan_busy_q   <= 1'b0;
      scan_done_q   <= 1'b0;
      scan_hit_q    <= 1'b0;
      scan_code_q   <= 8'h00;
      scan_ptr_q    <= 8'h00;
      scan_end_q    <= 8'h00;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      rr_last_q     <= rr_last_d;
      cnt_q         <= cnt_d;
      kb_addr_q     <= kb_addr_d;
      cpu_ack_q     <= cpu_ack_d;
      cpu_pressed_q <= cpu_pressed_d;
      scan_busy_q   <= scan_busy_d;
      scan_done_q   <= scan_done_d;
      scan_hit_q    <= scan_hit_d;
      scan_code_q   <= scan_code_d;
      scan_ptr_q    <= scan_ptr_d;
      scan_end_q    <= scan_end_d;
    end
  end

  assign kb_addr     = kb_addr_q;
  assign cpu_ack     = cpu_ack_q;
  assign cpu_pressed = cpu_pressed_q;
  assign scan_busy   = scan_busy_q;
  assign scan_done   = scan_done_q;
  assign scan_hit    = scan_hit_q;
  assign scan_code   = scan_code_q;

endmodule
